// File: rtl/jk_pkg.sv
// Shared definitions for the jkff command driver: op encodings, FSM states
// and the next-q function of a JK flop.
package jk_pkg;

    typedef logic [1:0] jk_op_t;

    localparam jk_op_t JK_HOLD   = 2'b00;
    localparam jk_op_t JK_RESET  = 2'b01;
    localparam jk_op_t JK_SET    = 2'b10;
    localparam jk_op_t JK_TOGGLE = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } jk_state_e;

    function automatic logic jk_next(input jk_op_t op, input logic q);
        logic nq;
        case (op)
            JK_HOLD:   nq = q;
            JK_RESET:  nq = 1'b0;
            JK_SET:    nq = 1'b1;
            JK_TOGGLE: nq = ~q;
            default:   nq = q;
        endcase
        return nq;
    endfunction

endpackage

// File: rtl/jk_cmd_driver_if.sv
// Command handshake bus into the jkff command driver.
interface jk_cmd_driver_if #(
    parameter int LEN_W = 4
) ();
    import jk_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    jk_op_t           cmd_op;
    logic [LEN_W-1:0] cmd_len;

    modport master (output cmd_valid, output cmd_op, output cmd_len, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_len, output cmd_ready);

endinterface

// File: rtl/jk_cmd_fifo.sv
// Synchronous command FIFO with flush; a full FIFO refuses pushes even when
// a pop happens in the same cycle.
module jk_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full  = (count_r == CNT_W'(DEPTH));
    assign empty = (count_r == CNT_W'(0));
    assign count = count_r;
    assign rdata = mem_r[rd_ptr_r];

    // Qualified push/pop strobes
    always_comb begin
        do_push_s = push && !full && !flush;
        do_pop_s  = pop && !empty && !flush;
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

endmodule

// File: rtl/jk_cmd_driver.sv
// Replays buffered {op, length} commands as registered j/k pairs for a jkff
// and checks the flop's fed-back q against a cycle-accurate model.
module jk_cmd_driver
    import jk_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LEN_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    jk_cmd_driver_if.slave         cmd,
    input  logic                   flush,
    output logic                   j,
    output logic                   k,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    input  logic                   q_fb,
    output logic                   exp_q,
    output logic                   mismatch,
    input  logic                   mismatch_clr
);
    localparam int WIDTH = 2 + LEN_W;

    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             push_s;
    logic             pop_s;
    logic [WIDTH-1:0] head_s;

    jk_state_e        state_r, state_s;
    logic [LEN_W-1:0] rem_r, rem_s;
    jk_op_t           jk_s;
    logic             j_r, k_r, busy_r;
    logic             exp_q_r, armed_r, mismatch_r;

    assign cmd.cmd_ready = rst && !fifo_full_s && !flush;
    assign push_s        = cmd.cmd_valid && cmd.cmd_ready;

    jk_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .flush (flush),
        .wdata ({cmd.cmd_op, cmd.cmd_len}),
        .rdata (head_s),
        .count (fifo_count),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Next state: finishing a command pops the next one with no bubble
    always_comb begin
        state_s = state_r;
        rem_s   = rem_r;
        jk_s    = {j_r, k_r};
        pop_s   = 1'b0;
        if (flush) begin
            state_s = ST_IDLE;
            rem_s   = '0;
            jk_s    = JK_HOLD;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!fifo_empty_s) begin
                        pop_s   = 1'b1;
                        state_s = ST_DRIVE;
                        jk_s    = head_s[WIDTH-1 -: 2];
                        rem_s   = head_s[LEN_W-1:0];
                    end else begin
                        jk_s    = JK_HOLD;
                    end
                end
                ST_DRIVE: begin
                    if (rem_r != LEN_W'(0)) begin
                        rem_s   = rem_r - LEN_W'(1);
                    end else if (!fifo_empty_s) begin
                        pop_s   = 1'b1;
                        jk_s    = head_s[WIDTH-1 -: 2];
                        rem_s   = head_s[LEN_W-1:0];
                    end else begin
                        state_s = ST_IDLE;
                        jk_s    = JK_HOLD;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    rem_s   = '0;
                    jk_s    = JK_HOLD;
                end
            endcase
        end
    end

    // FSM state and registered j/k/busy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            rem_r   <= '0;
            j_r     <= 1'b0;
            k_r     <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            rem_r   <= rem_s;
            j_r     <= jk_s[1];
            k_r     <= jk_s[0];
            busy_r  <= (state_s == ST_DRIVE);
        end
    end

    // Flop model and sticky compare; a fresh difference beats a same-edge clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q_r    <= 1'b0;
            armed_r    <= 1'b0;
            mismatch_r <= 1'b0;
        end else begin
            exp_q_r <= jk_next({j_r, k_r}, exp_q_r);
            armed_r <= 1'b1;
            if (armed_r && (q_fb != exp_q_r)) begin
                mismatch_r <= 1'b1;
            end else if (mismatch_clr) begin
                mismatch_r <= 1'b0;
            end else begin
                mismatch_r <= mismatch_r;
            end
        end
    end

    assign j        = j_r;
    assign k        = k_r;
    assign busy     = busy_r;
    assign exp_q    = exp_q_r;
    assign mismatch = mismatch_r;

endmodule
